// File: rtl/hot_seq_pkg.sv
// hot_seq_pkg: pattern constants and checker state encoding shared by hot_seq_checker and hot_seq_phase
package hot_seq_pkg;
  localparam int SEQ_LEN = 7;
  localparam logic [SEQ_LEN-1:0] PATTERN = 7'b0001011;
  typedef enum logic [2:0] {HUNT = 3'b001, VERIFY = 3'b010, LOCKED = 3'b100} chk_state_t;
endpackage

// File: rtl/hot_seq_phase.sv
// hot_seq_phase: one-hot phase rotator; in clk reset load0 adv, out phase_oh expected at_last
module hot_seq_phase
  import hot_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load0,
  input  logic               adv,
  output logic [SEQ_LEN-1:0] phase_oh,
  output logic               expected,
  output logic               at_last
);
  always_ff @(posedge clk)
    if (reset || load0) phase_oh <= SEQ_LEN'(1);
    else if (adv) phase_oh <= {phase_oh[SEQ_LEN-2:0], phase_oh[SEQ_LEN-1]};
  assign expected = |(phase_oh & PATTERN);
  assign at_last  = phase_oh[SEQ_LEN-1];
endmodule

// File: rtl/hot_seq_checker.sv
// hot_seq_checker: aligns to the 1101000 pattern on din and flags bit errors; in clk reset din din_valid clr_count, out locked err phase_oh err_count
module hot_seq_checker
  import hot_seq_pkg::*;
#(
  parameter int LOCK_PERIODS  = 2,
  parameter int UNLOCK_MISSES = 3,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clr_count,
  output logic               locked,
  output logic               err,
  output logic [SEQ_LEN-1:0] phase_oh,
  output logic [CNT_W-1:0]   err_count
);
  localparam int PW = $clog2(LOCK_PERIODS + 1);
  localparam int MW = $clog2(UNLOCK_MISSES + 1);
  chk_state_t state, state_nxt;
  logic [SEQ_LEN-2:0] hist;
  logic [SEQ_LEN-1:0] shifted;
  logic [PW-1:0] period_cnt;
  logic [MW-1:0] miss_run;
  logic load0, adv, expected, at_last, mismatch, lock_err;
  hot_seq_phase u_phase (
    .clk      (clk),
    .reset    (reset),
    .load0    (load0),
    .adv      (adv),
    .phase_oh (phase_oh),
    .expected (expected),
    .at_last  (at_last)
  );
  assign shifted  = {din, hist};
  assign mismatch = din ^ expected;
  assign lock_err = din_valid && state == LOCKED && mismatch;
  assign locked   = state == LOCKED;
  always_comb begin
    state_nxt = state;
    load0 = 1'b0;
    adv = 1'b0;
    case (state)
      HUNT: begin
        load0 = din_valid;
        if (din_valid && shifted == PATTERN) state_nxt = VERIFY;
      end
      VERIFY: if (din_valid) begin
        load0 = mismatch;
        adv = !mismatch;
        if (mismatch) state_nxt = HUNT;
        else if (at_last && period_cnt == PW'(LOCK_PERIODS - 1)) state_nxt = LOCKED;
      end
      LOCKED: if (din_valid) begin
        adv = 1'b1;
        if (mismatch && miss_run == MW'(UNLOCK_MISSES - 1)) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= HUNT;
      hist <= '0;
      period_cnt <= '0;
      miss_run <= '0;
      err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      err <= lock_err;
      if (din_valid && state == HUNT) hist <= shifted[SEQ_LEN-1:1];
      period_cnt <= state != VERIFY ? '0 : (din_valid && !mismatch && at_last) ? period_cnt + PW'(1) : period_cnt;
      miss_run <= (state != LOCKED || (din_valid && !mismatch)) ? '0 : lock_err ? miss_run + MW'(1) : miss_run;
      err_count <= clr_count ? '0 : (lock_err && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
    end
endmodule

// File: tb/tb_hot_seq_checker.sv
// tb_hot_seq_checker: directed self-checking bench for hot_seq_checker
module tb_hot_seq_checker;
  logic clk = 1'b0, reset = 1'b1, din = 1'b0, din_valid = 1'b0, clr_count = 1'b0;
  logic locked, err, locked2, err2;
  logic [6:0] phase_oh, phase2;
  logic [7:0] err_count;
  logic [1:0] cnt2;
  logic [6:0] pat = 7'b0001011;
  int checks = 0, errors = 0, ph = 0;
  always #5 clk = ~clk;
  hot_seq_checker #(.LOCK_PERIODS(2), .UNLOCK_MISSES(3), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .locked(locked), .err(err), .phase_oh(phase_oh), .err_count(err_count)
  );
  hot_seq_checker #(.LOCK_PERIODS(2), .UNLOCK_MISSES(3), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .locked(locked2), .err(err2), .phase_oh(phase2), .err_count(cnt2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic d, input logic v);
    din = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic tx(input logic flip);
    step(pat[ph] ^ flip, 1'b1);
    ph = (ph + 1) % 7;
  endtask
  initial begin
    reset = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_locked", {locked, locked2}, 0);
    chk("rst_err", {err, err2}, 0);
    chk("rst_phase", phase_oh, 7'b0000001);
    chk("rst_phase2", phase2, 7'b0000001);
    chk("rst_count", {err_count, cnt2}, 0);
    reset = 1'b0;
    ph = 0;
    for (int n = 1; n <= 21; n++) begin
      tx(1'b0);
      chk("acq_locked", locked, n >= 21);
      chk("acq_err", err, 0);
      if (n == 6) chk("acq_ph6", phase_oh, 7'b0000001);
      if (n == 7) chk("acq_ph7", phase_oh, 7'b0000001);
      if (n == 8) chk("acq_ph8", phase_oh, 7'b0000010);
    end
    chk("acq_locked2", locked2, 1);
    repeat (3) tx(1'b0);
    tx(1'b1);
    chk("flip_err", err, 1);
    chk("flip_count", err_count, 1);
    chk("flip_count2", cnt2, 1);
    chk("flip_locked", locked, 1);
    chk("flip_phase", phase_oh, 7'b0010000);
    tx(1'b0);
    chk("flip_err_gone", err, 0);
    chk("flip_count_hold", err_count, 1);
    chk("flip_phase_next", phase_oh, 7'b0100000);
    chk("flip_still_locked", locked, 1);
    tx(1'b0);
    tx(1'b0);
    clr_count = 1'b1;
    tx(1'b0);
    clr_count = 1'b0;
    chk("clr_count", err_count, 0);
    chk("clr_count2", cnt2, 0);
    repeat (3) tx(1'b0);
    for (int i = 1; i <= 3; i++) begin
      tx(1'b1);
      chk("loss_err", err, 1);
      chk("loss_count", err_count, i);
      chk("loss_count2", cnt2, i);
      chk("loss_locked", locked, i < 3);
    end
    chk("loss_phase", phase_oh, 7'b0000001);
    for (int n = 1; n <= 21; n++) begin
      tx(1'b0);
      chk("relock_locked", locked, n >= 21);
      chk("relock_err", err, 0);
    end
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    ph = 0;
    chk("abort_rst", locked, 0);
    repeat (9) tx(1'b0);
    chk("abort_ph9", phase_oh, 7'b0000100);
    tx(1'b1);
    chk("abort_err", err, 0);
    chk("abort_count", err_count, 0);
    chk("abort_locked", locked, 0);
    chk("abort_phase", phase_oh, 7'b0000001);
    for (int n = 11; n <= 24; n++) begin
      tx(1'b0);
      chk("abort_nolock", locked, 0);
      chk("abort_noerr", err, 0);
      if (n == 11) chk("abort_hunt_phase", phase_oh, 7'b0000001);
    end
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    ph = 0;
    for (int n = 1; n <= 21; n++) begin
      repeat ($urandom_range(0, 2)) begin
        step(1'($urandom_range(0, 1)), 1'b0);
        chk("gap_idle_locked", locked, 0);
        chk("gap_idle_err", err, 0);
      end
      tx(1'b0);
      chk("gap_locked", locked, n >= 21);
    end
    step(1'b1, 1'b0);
    chk("gap_hold_locked", locked, 1);
    chk("gap_hold_phase", phase_oh, 7'b0000001);
    for (int e = 1; e <= 5; e++) begin
      repeat (3) tx(1'b0);
      tx(1'b1);
      chk("sat_err", err, 1);
      chk("sat_count", err_count, e);
      chk("sat_count2", cnt2, e > 3 ? 3 : e);
      repeat (3) tx(1'b0);
    end
    chk("sat_locked", locked2, 1);
    repeat (3) tx(1'b0);
    clr_count = 1'b1;
    tx(1'b1);
    clr_count = 1'b0;
    chk("clr_err_pulse", err, 1);
    chk("clr_wins", err_count, 0);
    chk("clr_wins2", cnt2, 0);
    chk("pre_reset_locked", locked, 1);
    reset = 1'b1;
    step(pat[ph] ^ 1'b1, 1'b1);
    chk("midrst_err", err, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_phase", phase_oh, 7'b0000001);
    chk("midrst_count", err_count, 0);
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
